// File: rtl/sfx_pkg.sv
// sfx_pkg: shared channel indices, FSM state type and ms prescaler helper for sfx_player.
package sfx_pkg;
    localparam int CH_WHISTLE = 0;
    localparam int CH_HIT     = 1;
    localparam int CH_SCORE   = 2;
    localparam int CH_ENDGAME = 3;

    typedef enum logic {IDLE, PLAY} state_e;

    function automatic int ms_cycles(input int clk_hz);
        return clk_hz / 1000;
    endfunction
endpackage

// File: rtl/sfx_tone_gen.sv
// sfx_tone_gen: square-wave divider; phase starts high on restart and is held low when half_period is 0.
module sfx_tone_gen #(
    parameter int TONE_W = 20
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              restart,
    input  logic [TONE_W-1:0] half_period,
    output logic              phase
);
    logic [TONE_W-1:0] cnt_q, cnt_d;
    logic              phase_q, phase_d;

    always_comb begin
        cnt_d   = cnt_q + TONE_W'(1);
        phase_d = phase_q;
        if (restart || half_period == '0) begin
            cnt_d   = '0;
            phase_d = restart && half_period != '0;
        end else if (cnt_q == half_period - TONE_W'(1)) begin
            cnt_d   = '0;
            phase_d = ~phase_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            phase_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end

    assign phase = phase_q;
endmodule

// File: rtl/sfx_player.sv
// sfx_player: priority/preempting square-wave sound player for PmodAMP2; SFX_DECAY_EN adds a PWM decay envelope.
module sfx_player
    import sfx_pkg::*;
#(
    parameter int CLK_HZ   = 100_000_000,
    parameter int N_CH     = 4,
    parameter int TONE_W   = 20,
    parameter int DUR_W    = 16,
    parameter int GAIN_HI  = 1,
    parameter int PWM_W    = 8,
    parameter int DECAY_MS = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_CH-1:0]           start,
    input  logic [N_CH*TONE_W-1:0]    half_period,
    input  logic [N_CH*DUR_W-1:0]     duration_ms,
    input  logic                      mute,
    output logic                      busy,
    output logic [$clog2(N_CH)-1:0]   active_ch,
    output logic                      done,
    output logic                      gain,
    output logic                      shut_down_n,
    output logic                      a_out
);
    localparam int CW  = $clog2(N_CH);
    localparam int MS  = ms_cycles(CLK_HZ);
    localparam int MSW = MS > 1 ? $clog2(MS) : 1;

    state_e            state_q, state_d;
    logic [CW-1:0]     ch_q, ch_d, cand;
    logic [TONE_W-1:0] hp_q, hp_d;
    logic [DUR_W-1:0]  dur_q, dur_d;
    logic [MSW-1:0]    ms_q, ms_d;
    logic              a_en_q, a_en_d;
    logic              cand_v, tick, expire, accept, phase;

    // Highest index wins; zero-duration requests never become candidates.
    always_comb begin
        cand_v = 1'b0;
        cand   = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (start[i] && duration_ms[i*DUR_W +: DUR_W] != '0) begin
                cand_v = 1'b1;
                cand   = CW'(i);
            end
        end
    end

    assign tick   = state_q == PLAY && ms_q == MSW'(MS - 1);
    assign expire = tick && dur_q == DUR_W'(1);
    assign accept = cand_v && (state_q == IDLE || expire || cand > ch_q);

    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        hp_d    = hp_q;
        dur_d   = dur_q;
        ms_d    = ms_q;
        if (accept) begin
            state_d = PLAY;
            ch_d    = cand;
            hp_d    = half_period[int'(cand)*TONE_W +: TONE_W];
            dur_d   = duration_ms[int'(cand)*DUR_W +: DUR_W];
            ms_d    = '0;
        end else if (state_q == PLAY) begin
            ms_d    = tick ? '0 : ms_q + MSW'(1);
            dur_d   = tick ? dur_q - DUR_W'(1) : dur_q;
            state_d = expire ? IDLE : PLAY;
        end
        a_en_d = state_d == PLAY && !mute;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ch_q    <= '0;
            hp_q    <= '0;
            dur_q   <= '0;
            ms_q    <= '0;
            a_en_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
            hp_q    <= hp_d;
            dur_q   <= dur_d;
            ms_q    <= ms_d;
            a_en_q  <= a_en_d;
        end
    end

    sfx_tone_gen #(.TONE_W(TONE_W)) u_tone (
        .clk        (clk),
        .rst        (rst),
        .restart    (accept),
        .half_period(hp_d),
        .phase      (phase)
    );

`ifdef SFX_DECAY_EN
    localparam int DCW = DECAY_MS > 1 ? $clog2(DECAY_MS) : 1;
    logic [PWM_W-1:0] lvl_q, lvl_d, pwm_q;
    logic [DCW-1:0]   dec_q, dec_d;
    logic             step;

    assign step = tick && dec_q == DCW'(DECAY_MS - 1);

    always_comb begin
        lvl_d = lvl_q;
        dec_d = dec_q;
        if (accept) begin
            lvl_d = '1;
            dec_d = '0;
        end else if (tick) begin
            dec_d = step ? '0 : dec_q + DCW'(1);
            lvl_d = step && lvl_q != '0 ? lvl_q - PWM_W'(1) : lvl_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lvl_q <= '0;
            dec_q <= '0;
            pwm_q <= '0;
        end else begin
            lvl_q <= lvl_d;
            dec_q <= dec_d;
            pwm_q <= pwm_q + PWM_W'(1);
        end
    end

    assign a_out = a_en_q & phase & (pwm_q < lvl_q);
`else
    assign a_out = a_en_q & phase;
`endif

    assign busy        = state_q == PLAY;
    assign shut_down_n = state_q == PLAY;
    assign active_ch   = ch_q;
    assign done        = expire;
    assign gain        = 1'(GAIN_HI);
endmodule

// File: tb/tb_sfx_player.sv
// tb_sfx_player: directed vector table plus hand sequences for sfx_player at CLK_HZ=10_000 (1 ms = 10 cycles).
module tb_sfx_player;
    localparam int N = 4, TW = 20, DW = 16;

    logic            clk = 1'b0;
    logic            rst, mute;
    logic [N-1:0]    start;
    logic [N*TW-1:0] hp;
    logic [N*DW-1:0] dur;
    logic            busy, done, gain, sdn, a_out;
    logic [1:0]      ach;

    int n_cmp = 0, n_bad = 0;

    sfx_player #(.CLK_HZ(10_000), .N_CH(N), .TONE_W(TW), .DUR_W(DW)) dut (
        .clk(clk), .rst(rst), .start(start), .half_period(hp), .duration_ms(dur),
        .mute(mute), .busy(busy), .active_ch(ach), .done(done), .gain(gain),
        .shut_down_n(sdn), .a_out(a_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] st;
        logic [3:0] nz;
        logic       e_busy;
        logic [1:0] e_ch;
    } sel_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ch(input int c, input int h, input int d);
        hp[c*TW +: TW]  = TW'(h);
        dur[c*DW +: DW] = DW'(d);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        start = '0;
        mute = 1'b0;
        hp = '0;
        dur = '0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic pulse(input logic [3:0] s);
        start = s;
        tick();
        start = '0;
    endtask

    function automatic logic ph3(input int k);
        return ((k - 1) / 3) % 2 == 0;
    endfunction

    sel_t vec[7];

    initial begin
        int dk, nd;
        vec[0] = '{4'b0001, 4'b1111, 1'b1, 2'd0};
        vec[1] = '{4'b0110, 4'b1111, 1'b1, 2'd2};
        vec[2] = '{4'b0110, 4'b1011, 1'b1, 2'd1};
        vec[3] = '{4'b0110, 4'b1001, 1'b0, 2'd0};
        vec[4] = '{4'b1111, 4'b0111, 1'b1, 2'd2};
        vec[5] = '{4'b1000, 4'b1111, 1'b1, 2'd3};
        vec[6] = '{4'b0000, 4'b1111, 1'b0, 2'd0};

        rst = 1'b1; start = '0; mute = 1'b0; hp = '0; dur = '0;
        tick();
        tick();
        chk("rst_busy", busy, 0);
        chk("rst_ch", ach, 0);
        chk("rst_done", done, 0);
        chk("rst_aout", a_out, 0);
        chk("rst_sdn", sdn, 0);
        chk("rst_gain", gain, 1);

        for (int v = 0; v < 7; v++) begin
            do_reset();
            for (int c = 0; c < N; c++) set_ch(c, 5, vec[v].nz[c] ? 3 : 0);
            pulse(vec[v].st);
            chk($sformatf("sel%0d_busy", v), busy, vec[v].e_busy);
            chk($sformatf("sel%0d_ch", v), ach, vec[v].e_ch);
            chk($sformatf("sel%0d_sdn", v), sdn, vec[v].e_busy);
            chk($sformatf("sel%0d_aout", v), a_out, vec[v].e_busy);
        end

        // basic play: ch0 hp=3 dur=2
        do_reset();
        set_ch(0, 3, 2);
        pulse(4'b0001);
        for (int k = 1; k <= 20; k++) begin
            chk($sformatf("basic_aout_k%0d", k), a_out, ph3(k));
            chk($sformatf("basic_done_k%0d", k), done, k == 20);
            chk($sformatf("basic_busy_k%0d", k), busy, 1);
            if (k == 3) set_ch(0, 7, 9);
            tick();
        end
        chk("basic_end_busy", busy, 0);
        chk("basic_end_aout", a_out, 0);
        chk("basic_end_sdn", sdn, 0);
        chk("basic_end_done", done, 0);

        // preemption: ch1 dur 5, ch3 at 2 ms
        do_reset();
        set_ch(1, 4, 5);
        set_ch(3, 2, 2);
        pulse(4'b0010);
        chk("pre_ch1", ach, 1);
        nd = 0;
        for (int k = 1; k < 20; k++) begin
            nd += int'(done);
            tick();
        end
        pulse(4'b1000);
        chk("pre_ch3", ach, 3);
        chk("pre_aout", a_out, 1);
        dk = 0;
        for (int k = 1; k <= 20; k++) begin
            if (done) begin
                nd++;
                if (dk == 0) dk = k;
            end
            start = (k == 5) ? 4'b0010 : 4'b0000;
            tick();
            if (k == 5) chk("pre_ignore_ch", ach, 3);
        end
        start = '0;
        chk("pre_done_k", dk, 20);
        chk("pre_busy_end", busy, 0);
        for (int k = 0; k < 40; k++) begin
            nd += int'(done);
            tick();
        end
        chk("pre_done_count", nd, 1);

        // expiry coincident with start[0]
        do_reset();
        set_ch(2, 3, 1);
        set_ch(0, 5, 1);
        pulse(4'b0100);
        for (int k = 1; k < 10; k++) tick();
        chk("coin_done", done, 1);
        chk("coin_ch2", ach, 2);
        pulse(4'b0001);
        chk("coin_busy", busy, 1);
        chk("coin_ch0", ach, 0);
        chk("coin_aout", a_out, 1);
        chk("coin_done_clr", done, 0);
        for (int k = 1; k < 10; k++) tick();
        chk("coin_done2", done, 1);
        tick();
        chk("coin_idle", busy, 0);

        // mute for the first ms, then released
        do_reset();
        set_ch(0, 3, 2);
        mute = 1'b1;
        pulse(4'b0001);
        for (int k = 1; k <= 20; k++) begin
            chk($sformatf("mute_aout_k%0d", k), a_out, k >= 10 && ph3(k));
            chk($sformatf("mute_done_k%0d", k), done, k == 20);
            if (k == 9) mute = 1'b0;
            tick();
        end
        chk("mute_end_busy", busy, 0);

        // half_period = 0
        do_reset();
        set_ch(1, 0, 1);
        pulse(4'b0010);
        chk("hp0_busy", busy, 1);
        for (int k = 1; k <= 10; k++) begin
            chk($sformatf("hp0_aout_k%0d", k), a_out, 0);
            chk($sformatf("hp0_done_k%0d", k), done, k == 10);
            tick();
        end

        // reset mid-play
        do_reset();
        set_ch(3, 3, 2);
        pulse(4'b1000);
        for (int k = 0; k < 5; k++) tick();
        rst = 1'b1;
        tick();
        chk("mid_busy", busy, 0);
        chk("mid_aout", a_out, 0);
        chk("mid_sdn", sdn, 0);
        chk("mid_gain", gain, 1);
        rst = 1'b0;
        nd = 0;
        for (int k = 0; k < 30; k++) begin
            nd += int'(done);
            tick();
        end
        chk("mid_no_done", nd, 0);
        chk("mid_idle", busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
